// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// Handshaked RV32I integer execute unit. Decodes the ALU operation from
// {alu_op, funct3, funct7_5, opcode_5}. Shifts run iteratively, SHIFT_STEP
// bit positions per cycle. Every other operation completes in one cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake (operands and decode fields)
//   alu_op, funct3,
//   funct7_5, opcode_5   operation select
//   op_a, op_b           operands (op_b also carries shift amount / imm)
//   out_valid/out_ready  result handshake
//   result, zero,
//   illegal              registered result and flags, valid with out_valid
// ----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            opcode_5,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHAMT_W = $clog2(XLEN);
    // One extra bit so that SHIFT_STEP == XLEN is still representable.
    localparam logic [SHAMT_W:0] STEP_L = SHIFT_STEP[SHAMT_W:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9,
        OP_ILL  = 4'd10
    } op_t;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                zero_q, zero_d;
    logic                ill_q, ill_d;
    logic [XLEN-1:0]     sh_q, sh_d;
    logic [SHAMT_W-1:0]  rem_q, rem_d;
    logic                left_q, left_d;
    logic                arith_q, arith_d;

    op_t                 op_s;
    logic [XLEN-1:0]     alu_res_s;
    logic [SHAMT_W-1:0]  shamt_s;
    logic                go_shift_s;
    logic                accept_s;
    logic                load_s;
    logic [SHAMT_W:0]    step_s;
    logic [XLEN-1:0]     shifted_s;
    logic [SHAMT_W-1:0]  rem_next_s;

    assign shamt_s  = op_b[SHAMT_W-1:0];
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_s = in_valid && in_ready;

    // Operation decode from the instruction fields
    always_comb begin
        op_s = OP_ADD;
        case (alu_op)
            2'b00: op_s = OP_ADD;
            2'b01: op_s = OP_SUB;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (opcode_5 && funct7_5) op_s = OP_SUB;
                        else                      op_s = OP_ADD;
                    end
                    3'b001: op_s = OP_SLL;
                    3'b010: op_s = OP_SLT;
                    3'b011: op_s = OP_SLTU;
                    3'b100: op_s = OP_XOR;
                    3'b101: begin
                        // funct7_5 selects arithmetic shift for R- and I-type alike
                        if (funct7_5) op_s = OP_SRA;
                        else          op_s = OP_SRL;
                    end
                    3'b110: op_s = OP_OR;
                    3'b111: op_s = OP_AND;
                    default: op_s = OP_ILL;
                endcase
            end
            2'b11:   op_s = OP_ILL;
            default: op_s = OP_ILL;
        endcase
    end

    // Single-cycle result; shifts yield op_a here, which is the shamt == 0 answer
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (op_s)
            OP_ADD:  alu_res_s = op_a + op_b;
            OP_SUB:  alu_res_s = op_a - op_b;
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_res_s = op_a ^ op_b;
            OP_OR:   alu_res_s = op_a | op_b;
            OP_AND:  alu_res_s = op_a & op_b;
            OP_SLL:  alu_res_s = op_a;
            OP_SRL:  alu_res_s = op_a;
            OP_SRA:  alu_res_s = op_a;
            OP_ILL:  alu_res_s = {XLEN{1'b0}};
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    assign go_shift_s = ((op_s == OP_SLL) || (op_s == OP_SRL) || (op_s == OP_SRA))
                        && (shamt_s != {SHAMT_W{1'b0}});

    // One iterative shift step of min(SHIFT_STEP, remaining) positions
    always_comb begin
        if ({1'b0, rem_q} < STEP_L) step_s = {1'b0, rem_q};
        else                        step_s = STEP_L;
        if (left_q)       shifted_s = sh_q << step_s;
        else if (arith_q) shifted_s = $unsigned($signed(sh_q) >>> step_s);
        else              shifted_s = sh_q >> step_s;
        // step_s never exceeds rem_q, so its top bit is irrelevant here
        rem_next_s = rem_q - step_s[SHAMT_W-1:0];
    end

    // Next-state, shift datapath and result register update
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        left_d  = left_q;
        arith_d = arith_q;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) load_s  = 1'b1;
                else          state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                sh_d  = shifted_s;
                rem_d = rem_next_s;
                if (rem_next_s == {SHAMT_W{1'b0}}) begin
                    state_d = ST_DONE;
                    res_d   = shifted_s;
                    zero_d  = (shifted_s == {XLEN{1'b0}});
                    ill_d   = 1'b0;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // Consuming the result and accepting the next request can coincide
                if (out_ready) begin
                    if (accept_s) load_s  = 1'b1;
                    else          state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_s) begin
            if (go_shift_s) begin
                state_d = ST_SHIFT;
                sh_d    = op_a;
                rem_d   = shamt_s;
                left_d  = (op_s == OP_SLL);
                arith_d = (op_s == OP_SRA);
            end else begin
                state_d = ST_DONE;
                res_d   = alu_res_s;
                zero_d  = (alu_res_s == {XLEN{1'b0}});
                ill_d   = (op_s == OP_ILL);
            end
        end else begin
            // no request taken: keep the per-state decision made above
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            res_q   <= {XLEN{1'b0}};
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
            sh_q    <= {XLEN{1'b0}};
            rem_q   <= {SHAMT_W{1'b0}};
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed, self-checking bench. Two instances: SHIFT_STEP = 1 and
// SHIFT_STEP = 4, sharing the decode/operand inputs and out_ready; sel
// chooses which instance receives in_valid and is observed. Expected
// results are pushed to a scoreboard queue when a request is issued and
// popped when out_valid is seen.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv;
    logic        sel;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        opcode_5;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_ready;

    logic        in_valid1, in_ready1, out_valid1, zero1, illegal1;
    logic        in_valid4, in_ready4, out_valid4, zero4, illegal4;
    logic [31:0] result1, result4;

    logic        ir_s, ov_s, z_s, il_s;
    logic [31:0] res_s;

    always #5 clk = ~clk;

    assign in_valid1 = iv & ~sel;
    assign in_valid4 = iv & sel;
    assign ir_s  = sel ? in_ready4  : in_ready1;
    assign ov_s  = sel ? out_valid4 : out_valid1;
    assign res_s = sel ? result4    : result1;
    assign z_s   = sel ? zero4      : zero1;
    assign il_s  = sel ? illegal4   : illegal1;

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .opcode_5(opcode_5),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .zero(zero1), .illegal(illegal1)
    );

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .opcode_5(opcode_5),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid4), .out_ready(out_ready),
        .result(result4), .zero(zero4), .illegal(illegal4)
    );

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   tests = 0;
    int   fails = 0;
    int   last_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive a request at a negedge, wait for in_ready, let it be accepted, then scramble inputs.
    task automatic issue(input string tag, input logic s, input logic [1:0] ao,
                         input logic [2:0] f3, input logic f7, input logic o5,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic eil,
                         input int elat);
        exp_t e;
        int   n;
        sel = s; alu_op = ao; funct3 = f3; funct7_5 = f7; opcode_5 = o5;
        op_a = a; op_b = b; iv = 1'b1;
        e.tag = tag; e.res = er; e.z = ez; e.ill = eil; e.lat = elat;
        sb.push_back(e);
        #1;
        n = 0;
        while (!ir_s && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        last_wait = n;
        chk({tag, ":accepted"}, {31'd0, (n < 100)}, 32'd1);
        @(posedge clk);
        #1;
        iv = 1'b0;
        op_a = $urandom; op_b = $urandom;
        alu_op = 2'($urandom_range(0, 3)); funct3 = 3'($urandom_range(0, 7));
        funct7_5 = 1'($urandom_range(0, 1)); opcode_5 = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for out_valid, then compare latency and outputs with the scoreboard head.
    task automatic collect();
        exp_t e;
        int   lat;
        int   busy_hi;
        lat = 0;
        busy_hi = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!ov_s && ir_s) busy_hi++;
        end while (!ov_s && lat < 200);
        if (sb.size() != 0) begin
            e = sb.pop_front();
        end else begin
            e.tag = "empty_sb"; e.res = 32'd0; e.z = 1'b0; e.ill = 1'b0; e.lat = -1;
        end
        last_exp = e;
        chk({e.tag, ":latency"},   32'(lat),      32'(e.lat));
        chk({e.tag, ":result"},    res_s,         e.res);
        chk({e.tag, ":zero"},      {31'd0, z_s},  {31'd0, e.z});
        chk({e.tag, ":illegal"},   {31'd0, il_s}, {31'd0, e.ill});
        chk({e.tag, ":busy_ready"}, 32'(busy_hi), 32'd0);
    endtask

    initial begin
        int ov_seen;
        iv = 1'b0; sel = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; opcode_5 = 1'b0;
        op_a = 32'd0; op_b = 32'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset:out_valid", {31'd0, out_valid1}, 32'd0);
        chk("reset:result",    result1,             32'd0);
        chk("reset:zero",      {31'd0, zero1},      32'd0);
        chk("reset:illegal",   {31'd0, illegal1},   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset:in_ready", {31'd0, in_ready1}, 32'd1);

        // ADD / SUB / SLT / SLTU on 0xFFFF_FFFF and 1
        issue("add_wrap", 1'b0, 2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0, 1);
        collect();
        issue("sub_r",    1'b0, 2'b10, 3'b000, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        collect();
        issue("slt",      1'b0, 2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
        collect();
        issue("sltu",     1'b0, 2'b10, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
        collect();
        // I-type funct3 000 with bit 30 set is still ADD
        issue("addi_f7",  1'b0, 2'b10, 3'b000, 1'b1, 1'b0, 32'd10, 32'd3, 32'd13, 1'b0, 1'b0, 1);
        collect();
        issue("xor",      1'b0, 2'b10, 3'b100, 1'b0, 1'b1, 32'hF0F0_0000, 32'h0FF0_00FF, 32'hFF00_00FF, 1'b0, 1'b0, 1);
        collect();
        issue("or",       1'b0, 2'b10, 3'b110, 1'b0, 1'b1, 32'h0000_1200, 32'h0034_0000, 32'h0034_1200, 1'b0, 1'b0, 1);
        collect();
        issue("and",      1'b0, 2'b10, 3'b111, 1'b0, 1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0, 1);
        collect();

        // Shifts at SHIFT_STEP = 1
        issue("sra31",    1'b0, 2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
        collect();
        issue("srl0",     1'b0, 2'b10, 3'b101, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1);
        collect();
        issue("sll0",     1'b0, 2'b10, 3'b001, 1'b0, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 1);
        collect();
        issue("sll4",     1'b0, 2'b10, 3'b001, 1'b0, 1'b1, 32'h0000_00F1, 32'hFFFF_FF04, 32'h0000_0F10, 1'b0, 1'b0, 5);
        collect();
        issue("srai4",    1'b0, 2'b10, 3'b101, 1'b1, 1'b0, 32'hF000_0000, 32'd4, 32'hFF00_0000, 1'b0, 1'b0, 5);
        collect();

        // Shifts at SHIFT_STEP = 4
        issue("s4_sll7",  1'b1, 2'b10, 3'b001, 1'b0, 1'b1, 32'd1, 32'd7, 32'h0000_0080, 1'b0, 1'b0, 3);
        collect();
        issue("s4_srl7",  1'b1, 2'b10, 3'b101, 1'b0, 1'b1, 32'h0000_0080, 32'd7, 32'd1, 1'b0, 1'b0, 3);
        collect();
        issue("s4_sra31", 1'b1, 2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 9);
        collect();

        // Fixed and illegal operations
        issue("illegal",  1'b0, 2'b11, 3'b000, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 1'b1, 1'b1, 1);
        collect();
        issue("add_fix",  1'b0, 2'b00, 3'b111, 1'b1, 1'b1, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1);
        collect();
        issue("sub_fix",  1'b0, 2'b01, 3'b110, 1'b0, 1'b0, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 1);
        collect();

        // Backpressure: hold the result five cycles, then consume and accept together
        issue("bp_hold",  1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1);
        out_ready = 1'b0;
        collect();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp:result",    res_s,          last_exp.res);
            chk("bp:zero",      {31'd0, z_s},   {31'd0, last_exp.z});
            chk("bp:illegal",   {31'd0, il_s},  {31'd0, last_exp.ill});
            chk("bp:out_valid", {31'd0, ov_s},  32'd1);
            chk("bp:in_ready",  {31'd0, ir_s},  32'd0);
        end
        out_ready = 1'b1;
        issue("bp_next",  1'b0, 2'b10, 3'b100, 1'b0, 1'b1, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_0FF0, 1'b0, 1'b0, 1);
        chk("bp:same_cycle_accept", 32'(last_wait), 32'd0);
        collect();

        // Reset in the middle of a shift (illegal flag left set by the previous op)
        issue("pre_ill",  1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 1);
        collect();
        issue("rst_shift", 1'b0, 2'b10, 3'b101, 1'b0, 1'b1, 32'hFFFF_0000, 32'd20, 32'h0000_0FFF, 1'b0, 1'b0, 21);
        repeat (5) @(negedge clk);
        chk("rst_mid:out_valid_pre", {31'd0, ov_s}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid:out_valid", {31'd0, out_valid1}, 32'd0);
        chk("rst_mid:result",    result1,             32'd0);
        chk("rst_mid:illegal",   {31'd0, illegal1},   32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid1) ov_seen++;
        end
        chk("rst_mid:no_stale", 32'(ov_seen), 32'd0);
        chk("rst_mid:in_ready", {31'd0, in_ready1}, 32'd1);
        issue("post_rst", 1'b0, 2'b10, 3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'd2, 32'h0000_000C, 1'b0, 1'b0, 3);
        collect();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
